// File: rtl/spi_dac_tx.sv
// Purpose: SPI master for a DAC. It sends one FRAME_BITS word MSB first, and sclk idles high.
// Latency: cs_n falls 1 cycle after start. done pulses CLK_DIV*(2*FRAME_BITS+2)+1 cycles after start.
// Backpressure: start is dropped while busy. Define SPI_DAC_TX_HOLD_REG_EN to queue one word instead.
module spi_dac_tx #(
    parameter int CLK_DIV    = 2,
    parameter int FRAME_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] data_in,
    output logic                  sclk,
    output logic                  cs_n,
    output logic                  mosi,
    output logic                  busy,
    output logic                  done,
    output logic                  hold_full
);

    localparam int              BW       = $clog2(FRAME_BITS + 1);
    localparam logic [7:0]      DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0]   BIT_ONE  = BW'(1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t                  state_q, state_d;
    logic [7:0]              div_q, div_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic                    sclk_q, sclk_d;
    logic                    cs_n_q, cs_n_d;
    logic                    mosi_q, mosi_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    load;
    logic [FRAME_BITS-1:0]   load_word;
    logic                    div_end;

`ifdef SPI_DAC_TX_HOLD_REG_EN
    logic [FRAME_BITS-1:0]   hold_q, hold_d;
    logic                    hold_full_q, hold_full_d;
`endif

    assign div_end = (div_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        load      = 1'b0;
        load_word = data_in;
`ifdef SPI_DAC_TX_HOLD_REG_EN
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
`endif
        case (state_q)
            IDLE: load = start;
            SETUP: begin
                if (div_end) begin
                    state_d = SHIFT;
                    div_d   = 8'd0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            SHIFT: begin
                // sclk_q tells us which half of the bit period is running.
                if (!div_end) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d = 8'd0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else if (bit_q == BIT_LAST) begin
                        state_d = HOLD;
                        sclk_d  = 1'b1;
                    end else begin
                        bit_d   = bit_q + BIT_ONE;
                        sclk_d  = 1'b1;
                        shreg_d = shreg_q << 1;
                        mosi_d  = shreg_q[FRAME_BITS-2];
                    end
                end
            end
            HOLD: begin
                if (div_end) begin
                    state_d = GAP;
                    div_d   = 8'd0;
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    mosi_d  = 1'b0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            GAP: begin
                if (div_end) begin
                    state_d = IDLE;
                    div_d   = 8'd0;
                    busy_d  = 1'b0;
`ifdef SPI_DAC_TX_HOLD_REG_EN
                    if (hold_full_q) begin
                        load        = 1'b1;
                        load_word   = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        load = start;
                    end
`endif
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (load) begin
            state_d = SETUP;
            div_d   = 8'd0;
            bit_d   = '0;
            shreg_d = load_word;
            sclk_d  = 1'b1;
            cs_n_d  = 1'b0;
            mosi_d  = load_word[FRAME_BITS-1];
            busy_d  = 1'b1;
        end

`ifdef SPI_DAC_TX_HOLD_REG_EN
        // A start accepted directly at GAP end is not also captured into the hold register.
        if (busy_q && start && !hold_full_q && !load) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= 8'd0;
            bit_q   <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b1;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef SPI_DAC_TX_HOLD_REG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end
    assign hold_full = hold_full_q;
`else
    assign hold_full = 1'b0;
`endif

    assign sclk = sclk_q;
    assign cs_n = cs_n_q;
    assign mosi = mosi_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_spi_dac_tx.sv
// Bench for spi_dac_tx. It predicts at transaction level: accept times, done times and words.
// A waveform decoder rebuilds each frame from sclk, cs_n and mosi.
module tb_spi_dac_tx;

    localparam int CD = 2;
    localparam int FB = 16;
    localparam int L  = CD * (2 * FB + 2);   // cs_n low cycles
    localparam int P  = CD * (2 * FB + 3);   // accept edge to GAP end
`ifdef SPI_DAC_TX_HOLD_REG_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, start;
    logic [15:0] data_in;
    logic sclk, cs_n, mosi, busy, done, hold_full;
    logic start2;
    logic [11:0] data2;
    logic sclk2, cs_n2, mosi2, busy2, done2, hold_full2;

    always #5 clk = ~clk;

    spi_dac_tx #(.CLK_DIV(CD), .FRAME_BITS(FB)) u_dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .busy(busy), .done(done), .hold_full(hold_full)
    );

    spi_dac_tx #(.CLK_DIV(1), .FRAME_BITS(12)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .data_in(data2),
        .sclk(sclk2), .cs_n(cs_n2), .mosi(mosi2), .busy(busy2), .done(done2), .hold_full(hold_full2)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          last_t = -100000;
    bit          hold_valid = 1'b0;
    logic [15:0] hold_word = '0;
    logic [15:0] exp_word[$];
    int          exp_done[$];
    bit          exp_busy = 1'b0;
    bit          exp_hold = 1'b0;

    logic        prev_cs = 1'b1, prev_sclk = 1'b1;
    int          low_start = 0, nbits = 0;
    logic [15:0] word = '0, last_word = '0;
    int          last_done = -1;

    typedef struct {
        logic [15:0] din;
        logic [15:0] exp_bits;
        int          done_off;
        int          idle_off;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic accept(input logic [15:0] w);
        last_t = cyc;
        exp_word.push_back(w);
        exp_done.push_back(cyc + L + 1);
    endtask

    task automatic model_step(input logic st, input logic [15:0] dat);
        if (HOLD_EN && hold_valid && cyc == last_t + P) begin
            accept(hold_word);
            hold_valid = 1'b0;
        end else if (st) begin
            if (cyc > last_t + P || (HOLD_EN && cyc == last_t + P)) begin
                accept(dat);
            end else if (HOLD_EN && !hold_valid) begin
                hold_valid = 1'b1;
                hold_word  = dat;
            end
        end
        exp_busy = (cyc + 1 > last_t) && (cyc + 1 <= last_t + P);
        exp_hold = hold_valid;
    endtask

    task automatic model_reset();
        exp_word.delete();
        exp_done.delete();
        last_t     = -100000;
        hold_valid = 1'b0;
        exp_busy   = 1'b0;
        exp_hold   = 1'b0;
        prev_cs    = 1'b1;
        prev_sclk  = 1'b1;
    endtask

    task automatic tick();
        bit exp_d;
        @(posedge clk);
        #1;
        cyc++;
        chk("busy", busy, exp_busy);
        chk("hold_full", hold_full, exp_hold);
        if (cs_n) chk("mosi_idle", mosi, 0);
        exp_d = (exp_done.size() > 0) && (exp_done[0] == cyc);
        chk("done", done, exp_d);
        if (exp_d) begin
            void'(exp_done.pop_front());
            last_done = cyc;
        end
        if (prev_cs && !cs_n) begin
            low_start = cyc;
            nbits     = 0;
            word      = '0;
        end
        if (!cs_n && !prev_cs && prev_sclk && !sclk) begin
            word = {word[14:0], mosi};
            nbits++;
        end
        if (!prev_cs && cs_n) begin
            chk("cs_low_len", cyc - low_start, L);
            chk("nbits", nbits, FB);
            if (exp_word.size() == 0) chk("frame_expected", exp_word.size(), 1);
            else chk("frame_word", word, exp_word.pop_front());
            last_word = word;
        end
        prev_cs   = cs_n;
        prev_sclk = sclk;
    endtask

    task automatic step(input logic st, input logic [15:0] dat);
        start   = st;
        data_in = dat;
        model_step(st, dat);
        tick();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_sclk"}, sclk, 1);
        chk({tag, "_cs_n"}, cs_n, 1);
        chk({tag, "_mosi"}, mosi, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_hold_full"}, hold_full, 0);
    endtask

    initial begin
        int t0, ndone, falls2, ones2, low2, ndone2;
        logic ps2;

        vecs[0] = '{16'hA5C3, 16'b1010_0101_1100_0011, 69, 71};
        vecs[1] = '{16'h0000, 16'b0000_0000_0000_0000, 69, 71};
        vecs[2] = '{16'hFFFF, 16'b1111_1111_1111_1111, 69, 71};
        vecs[3] = '{16'h8001, 16'b1000_0000_0000_0001, 69, 71};
        vecs[4] = '{16'h4002, 16'b0100_0000_0000_0010, 69, 71};

        rst = 1'b1; start = 1'b0; data_in = '0; start2 = 1'b0; data2 = '0;
        #1;
        chk_idle_outputs("reset");
        repeat (3) step(1'b0, 16'h0);
        rst = 1'b0;
        repeat (2) step(1'b0, 16'h0);

        // Single frames from the table; data_in keeps toggling to show it is ignored.
        for (int v = 0; v < 5; v++) begin
            last_done = -1;
            t0 = cyc;
            step(1'b1, vecs[v].din);
            for (int k = 0; k < 120 && !(busy == 1'b0 && cyc > t0 + 1); k++)
                step(1'b0, 16'($urandom));
            chk("tbl_word", last_word, vecs[v].exp_bits);
            chk("tbl_done_off", last_done - t0, vecs[v].done_off);
            chk("tbl_idle_off", cyc - t0, vecs[v].idle_off);
            repeat (3) step(1'b0, 16'h0);
        end

        // Second start 10 cycles into a frame.
        t0 = cyc;
        ndone = 0;
        step(1'b1, 16'h00FF);
        repeat (9) step(1'b0, 16'($urandom));
        step(1'b1, 16'h1234);
        chk("hold_at_11", hold_full, HOLD_EN);
        for (int k = 0; k < 250; k++) begin
            step(1'b0, 16'($urandom));
            if (done) ndone++;
        end
        chk("two_start_ndone", ndone, HOLD_EN ? 2 : 1);
        chk("two_start_last_word", last_word, HOLD_EN ? 16'h1234 : 16'h00FF);

        // Narrow instance: CLK_DIV=1, 12-bit all-ones frame.
        falls2 = 0; ones2 = 0; low2 = 0; ndone2 = 0; ps2 = 1'b1;
        data2 = 12'hFFF;
        for (int k = 0; k < 40; k++) begin
            start2 = (k == 0);
            step(1'b0, 16'h0);
            if (ps2 && !sclk2 && !cs_n2) begin
                falls2++;
                if (mosi2) ones2++;
            end
            if (!cs_n2) low2++;
            if (done2) ndone2++;
            ps2 = sclk2;
        end
        chk("dut2_falls", falls2, 12);
        chk("dut2_ones", ones2, 12);
        chk("dut2_cs_low", low2, 26);
        chk("dut2_done", ndone2, 1);

        // Reset 30 cycles into a frame, then a clean frame.
        step(1'b1, 16'($urandom));
        repeat (29) step(1'b0, 16'($urandom));
        #2 rst = 1'b1;
        #1;
        chk_idle_outputs("midreset");
        model_reset();
        step(1'b0, 16'h0);
        rst = 1'b0;
        repeat (80) step(1'b0, 16'($urandom));
        last_done = -1;
        t0 = cyc;
        step(1'b1, 16'h8001);
        for (int k = 0; k < 120 && !(busy == 1'b0 && cyc > t0 + 1); k++)
            step(1'b0, 16'($urandom));
        chk("post_rst_word", last_word, 16'h8001);
        chk("post_rst_done_off", last_done - t0, 69);

        // Random start pulses.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 24) == 0, 16'($urandom));
        repeat (300) step(1'b0, 16'h0);
        chk("queue_drained", exp_word.size() + exp_done.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_dac_tx.md
SPI_DAC_TX -- requirements
Module: spi_dac_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: SCLK half-period in clk cycles (legal values 1 to 255).
REQ-002 SHALL have parameter FRAME_BITS, default 16: bits per SPI frame (legal values 2 to 32).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: frame request, sampled on each clk edge (a one-cycle tick from the sample timer).
REQ-006 SHALL have port data_in, input, FRAME_BITS bits: frame word, captured in the cycle start is accepted.
REQ-007 SHALL have port sclk, output, 1 bit: SPI clock, idle high.
REQ-008 SHALL have port cs_n, output, 1 bit: active-low chip select.
REQ-009 SHALL have port mosi, output, 1 bit: serial data, MSB first.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when cs_n rises at frame end.
REQ-012 SHALL have port hold_full, output, 1 bit: hold register occupied (see Configuration).

Function
REQ-013 SHALL implement an FSM with states IDLE, SETUP, SHIFT, HOLD, GAP; all outputs registered.
REQ-014 In IDLE with start=1, SHALL load data_in into the shift register and enter SETUP, driving cs_n=0, busy=1 and mosi=data_in[MSB] from the next cycle.
REQ-015 SETUP SHALL last CLK_DIV cycles with sclk=1.
REQ-016 SHIFT SHALL send FRAME_BITS bit periods of 2*CLK_DIV cycles each: first half sclk=1, second half sclk=0; mosi updates only at bit-period start, so the DAC samples on the sclk falling edge.
REQ-017 After the last bit period, SHALL drive sclk=1 and enter HOLD for CLK_DIV cycles with cs_n still 0.
REQ-018 On HOLD->GAP, SHALL drive cs_n=1 and done=1 for exactly one cycle.
REQ-019 GAP SHALL last CLK_DIV cycles with cs_n=1; busy SHALL remain 1 throughout GAP; the FSM then returns to IDLE.
REQ-020 The cs_n low time SHALL be CLK_DIV*(2*FRAME_BITS+2) cycles (68 at defaults); done SHALL occur 1+that many cycles after the accepting edge (69 at defaults).
REQ-021 The bit counter SHALL be ceil(log2(FRAME_BITS+1)) bits wide, and the divider counter 8 bits wide; neither counter SHALL wrap within a frame.
REQ-022 mosi SHALL be 0 whenever cs_n=1.
REQ-023 Without the hold feature, start while busy=1 SHALL be ignored, and data_in SHALL have no effect outside the accepting cycle.

Reset
REQ-024 On rst=1, SHALL go immediately, without waiting for a clock edge, to state IDLE with sclk=1, cs_n=1, mosi=0, busy=0, done=0, hold_full=0, and all counters, shift register and hold register cleared.
REQ-025 Reset mid-frame SHALL abort the frame with no done pulse; the first start after rst deasserts SHALL begin a fresh frame from the MSB.

Configuration
REQ-026 SHALL support macro SPI_DAC_TX_HOLD_REG_EN, which gates a one-word hold register.
REQ-027 With SPI_DAC_TX_HOLD_REG_EN defined, start while busy=1 and hold_full=0 SHALL capture data_in and set hold_full=1; start while hold_full=1 SHALL be dropped and the held word kept.
REQ-028 With SPI_DAC_TX_HOLD_REG_EN defined and hold_full=1 at GAP end, SHALL go directly to SETUP with the held word and clear hold_full; busy SHALL stay 1.
REQ-029 With SPI_DAC_TX_HOLD_REG_EN defined, start in the same cycle as GAP end with hold_full=0 SHALL be accepted as if in IDLE.
REQ-030 Without SPI_DAC_TX_HOLD_REG_EN, hold_full SHALL be tied 0 and REQ-023 SHALL apply.

Verification
REQ-031 Defaults, data_in=16'hA5C3 with a one-cycle start -> 16 sclk falling edges with mosi sampled as 1010_0101_1100_0011, cs_n low 68 cycles, done exactly 69 cycles after the start edge, busy low 2 cycles later.
REQ-032 CLK_DIV=1, FRAME_BITS=12, data_in=12'hFFF -> 12 sclk falling edges with mosi=1 at each, cs_n low 26 cycles.
REQ-033 Without the macro, a second start with 16'h1234 at cycle 10 of a frame of 16'h00FF -> only 16'h00FF transmitted, one done pulse.
REQ-034 With the macro, the same stimulus as REQ-033 -> 16'h00FF then 16'h1234, cs_n high exactly CLK_DIV cycles between frames, two done pulses, hold_full high from cycle 11 until the second SETUP.
REQ-035 rst asserted 30 cycles into a frame -> cs_n=1, sclk=1, busy=0 immediately, no done; a new start with 16'h8001 -> complete, correct frame.
